// File: rtl/race_monitor_pkg.sv
// race_mon_pkg: shared types and constants for the race_monitor checker.
// FSM state encoding, violation codes and the rise-detect helper live here
// so the sampler and the top agree on one definition.
package race_mon_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } race_state_t;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_SIMUL = 2'b01;
  localparam logic [1:0] ERR_MISS  = 2'b10;

  // Settle counter width; SETTLE is limited to 0..15.
  localparam int SETTLE_W = 4;

  // A rising edge: the current sample is high while the previous one was low.
  function automatic logic rise_of(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

endpackage

// File: rtl/race_monitor_if.sv
// race_monitor_if: bundles the checker's sampled inputs and status outputs.
// master drives the launch/capture samples and clr; slave is the checker.
// Optional macro RACE_MON_TIMESTAMP_EN adds the first_err_ts status field.
interface race_monitor_if #(
  parameter int CNT_W = 8,
  parameter int TS_W  = 16
);

  logic             clk_en;
  logic             q_d;
  logic             d_out;
  logic             clr;
  logic             armed;
  logic             err_pulse;
  logic [1:0]       err_code;
  logic             fail;
  logic [CNT_W-1:0] rise_cnt;
  logic [CNT_W-1:0] err_cnt;

  if (TS_W < 1) begin : g_ts_w_check
    $error("race_monitor_if: TS_W must be at least 1");
  end

`ifdef RACE_MON_TIMESTAMP_EN
  logic [TS_W-1:0]  first_err_ts;

  modport master (
    output clk_en, q_d, d_out, clr,
    input  armed, err_pulse, err_code, fail, rise_cnt, err_cnt, first_err_ts
  );

  modport slave (
    input  clk_en, q_d, d_out, clr,
    output armed, err_pulse, err_code, fail, rise_cnt, err_cnt, first_err_ts
  );
`else
  modport master (
    output clk_en, q_d, d_out, clr,
    input  armed, err_pulse, err_code, fail, rise_cnt, err_cnt
  );

  modport slave (
    input  clk_en, q_d, d_out, clr,
    output armed, err_pulse, err_code, fail, rise_cnt, err_cnt
  );
`endif

endinterface

// File: rtl/race_monitor_rise_sampler.sv
// rise_sampler: remembers the value seen at the previous divided-clock
// sample and flags a 0->1 change on the current one. The history loads on
// every enable edge (settle window and clr included) so the first evaluated
// sample never sees a stale reset value as a rise.
module rise_sampler
  import race_mon_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic clk_en,
  input  logic din,
  output logic rose
);

  logic prev_r;

  // Capture the input at each divided-clock edge; hold otherwise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_r <= 1'b0;
    end else if (clk_en) begin
      prev_r <= din;
    end else begin
      prev_r <= prev_r;
    end
  end

  // Rise flag is only meaningful on an enable edge, against the incoming value.
  always_comb begin
    rose = clk_en & rise_of(din, prev_r);
  end

endmodule

// File: rtl/race_monitor.sv
// race_monitor: checks that every rise of q_d is followed by a rise of d_out
// exactly one divided-clock sample later. Same-sample rises are races,
// absent captures are misses. Runs on the fast clock; clk_en marks samples.
// Optional macro RACE_MON_TIMESTAMP_EN adds a free-running cycle counter and
// the first_err_ts output holding its value at the first violation.
module race_monitor
  import race_mon_pkg::*;
#(
  parameter int CNT_W  = 8,
  parameter int SETTLE = 2,
  parameter int TS_W   = 16
) (
  input  logic           clock,
  input  logic           reset,
  race_monitor_if.slave  mon
);

  localparam logic [SETTLE_W-1:0] SETTLE_L = SETTLE_W'(SETTLE);
  localparam logic [CNT_W-1:0]    CNT_MAX  = {CNT_W{1'b1}};

  if ((SETTLE < 0) || (SETTLE > 15)) begin : g_settle_check
    $error("race_monitor: SETTLE must be in 0..15");
  end

  if (TS_W < 1) begin : g_ts_w_check
    $error("race_monitor: TS_W must be at least 1");
  end

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1'b1);
  endfunction

  race_state_t          state_r;
  race_state_t          state_nxt_s;
  logic                 rq_s;
  logic                 rd_s;
  logic [SETTLE_W-1:0]  settle_cnt_r;
  logic                 settle_active_s;
  logic                 eval_s;
  logic                 viol_s;
  logic [1:0]           viol_code_s;
  logic                 rise_inc_s;
  logic                 err_pulse_r;
  logic [1:0]           err_code_r;
  logic                 fail_r;
  logic [CNT_W-1:0]     rise_cnt_r;
  logic [CNT_W-1:0]     err_cnt_r;

  rise_sampler u_q_sampler (
    .clock  (clock),
    .reset  (reset),
    .clk_en (mon.clk_en),
    .din    (mon.q_d),
    .rose   (rq_s)
  );

  rise_sampler u_d_sampler (
    .clock  (clock),
    .reset  (reset),
    .clk_en (mon.clk_en),
    .din    (mon.d_out),
    .rose   (rd_s)
  );

  // A sample is evaluated only once the settle window has been consumed.
  always_comb begin
    settle_active_s = (settle_cnt_r < SETTLE_L);
    eval_s          = mon.clk_en & ~settle_active_s;
  end

  // Settle window: counts ignored samples after reset or clr.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      settle_cnt_r <= {SETTLE_W{1'b0}};
    end else if (mon.clr) begin
      settle_cnt_r <= {SETTLE_W{1'b0}};
    end else if (mon.clk_en && settle_active_s) begin
      settle_cnt_r <= settle_cnt_r + SETTLE_W'(1'b1);
    end else begin
      settle_cnt_r <= settle_cnt_r;
    end
  end

  // FSM state register; reset discards any pending expectation at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state plus the per-sample verdict (violation / good capture).
  always_comb begin
    state_nxt_s = state_r;
    viol_s      = 1'b0;
    viol_code_s = ERR_NONE;
    rise_inc_s  = 1'b0;
    if (mon.clr) begin
      // clr wins: back to IDLE and whatever this sample shows is dropped.
      state_nxt_s = IDLE;
    end else if (eval_s) begin
      case (state_r)
        IDLE: begin
          if (rq_s && rd_s) begin
            state_nxt_s = IDLE;
            viol_s      = 1'b1;
            viol_code_s = ERR_SIMUL;
          end else if (rq_s) begin
            state_nxt_s = ARMED;
          end else begin
            // A capture rise without a launch is not our concern.
            state_nxt_s = IDLE;
          end
        end
        ARMED: begin
          if (rd_s) begin
            rise_inc_s = 1'b1;
            if (rq_s) begin
              // Capture arrived, but a fresh launch raced it.
              state_nxt_s = ARMED;
              viol_s      = 1'b1;
              viol_code_s = ERR_SIMUL;
            end else begin
              state_nxt_s = IDLE;
            end
          end else begin
            // Expected capture never came; a new launch re-arms.
            state_nxt_s = rq_s ? ARMED : IDLE;
            viol_s      = 1'b1;
            viol_code_s = ERR_MISS;
          end
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // FSM output: armed reflects the registered state directly.
  always_comb begin
    mon.armed = (state_r == ARMED);
  end

  // Violation reporting: one-cycle pulse, last code and sticky fail.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_pulse_r <= 1'b0;
      err_code_r  <= ERR_NONE;
      fail_r      <= 1'b0;
    end else if (mon.clr) begin
      err_pulse_r <= 1'b0;
      err_code_r  <= ERR_NONE;
      fail_r      <= 1'b0;
    end else begin
      err_pulse_r <= viol_s;
      if (viol_s) begin
        err_code_r <= viol_code_s;
        fail_r     <= 1'b1;
      end else begin
        err_code_r <= err_code_r;
        fail_r     <= fail_r;
      end
    end
  end

  // Saturating event counters; both may step on the same sample.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rise_cnt_r <= {CNT_W{1'b0}};
      err_cnt_r  <= {CNT_W{1'b0}};
    end else if (mon.clr) begin
      rise_cnt_r <= {CNT_W{1'b0}};
      err_cnt_r  <= {CNT_W{1'b0}};
    end else begin
      rise_cnt_r <= rise_inc_s ? sat_inc(rise_cnt_r) : rise_cnt_r;
      err_cnt_r  <= viol_s     ? sat_inc(err_cnt_r)  : err_cnt_r;
    end
  end

  // Drive the status fields from their registers.
  always_comb begin
    mon.err_pulse = err_pulse_r;
    mon.err_code  = err_code_r;
    mon.fail      = fail_r;
    mon.rise_cnt  = rise_cnt_r;
    mon.err_cnt   = err_cnt_r;
  end

`ifdef RACE_MON_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt_r;
  logic [TS_W-1:0] first_ts_r;

  // Free-running cycle counter, wraps naturally; clr does not touch it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ts_cnt_r <= {TS_W{1'b0}};
    end else begin
      ts_cnt_r <= ts_cnt_r + TS_W'(1'b1);
    end
  end

  // Latch the counter on the first violation; fail_r low means none yet.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      first_ts_r <= {TS_W{1'b0}};
    end else if (mon.clr) begin
      first_ts_r <= {TS_W{1'b0}};
    end else if (viol_s && !fail_r) begin
      first_ts_r <= ts_cnt_r;
    end else begin
      first_ts_r <= first_ts_r;
    end
  end

  // Expose the captured timestamp.
  always_comb begin
    mon.first_err_ts = first_ts_r;
  end
`endif

endmodule
